// File: rtl/hub75_bcm.sv
// rtl/hub75_bcm.sv - HUB75 binary-coded-modulation row painter: shift, latch and timed show per bit-plane.
// Define HUB75_BCM_GUARD_EN to add a 2-cycle blanked guard between latch and on-time.
module hub75_bcm #(
    parameter int N_ROWS     = 32,
    parameter int N_PLANES   = 8,
    parameter int LEN_W      = 8,
    parameter int LOG_N_ROWS = $clog2(N_ROWS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LOG_N_ROWS-1:0]       bcm_row,
    input  logic                        bcm_row_first,
    input  logic                        bcm_go,
    output logic                        bcm_rdy,
    output logic [$clog2(N_PLANES)-1:0] shift_plane,
    output logic                        shift_go,
    input  logic                        shift_rdy,
    input  logic [LEN_W-1:0]            ctrl_len,
    output logic [LOG_N_ROWS-1:0]       phy_addr,
    output logic                        phy_le,
    output logic                        phy_blank
);

    localparam int PW = $clog2(N_PLANES);
    localparam int TW = LEN_W + N_PLANES;
    localparam logic [PW-1:0] LAST_PLANE = PW'(N_PLANES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WAIT,
        LATCH,
        SHOW
`ifdef HUB75_BCM_GUARD_EN
        , GUARD
`endif
    } state_t;

    state_t                state;
    logic [LOG_N_ROWS-1:0] row_reg;
    logic [PW-1:0]         plane;
    logic [LEN_W-1:0]      len_reg;
    logic [TW-1:0]         timer;
    logic [TW-1:0]         timer_load;
    logic [TW-1:0]         timer_nxt;
    logic                  load_on;
    logic                  wait_first;
`ifdef HUB75_BCM_GUARD_EN
    logic                  guard_cnt;
`endif

    // The on-time is loaded on the way into SHOW so the panel unblanks in the SHOW cycle itself.
    always_comb begin
        timer_load = (TW'(len_reg) + TW'(1)) << plane;
`ifdef HUB75_BCM_GUARD_EN
        load_on    = (state == GUARD) && guard_cnt;
`else
        load_on    = (state == LATCH);
`endif
        if (load_on) begin
            timer_nxt = timer_load;
        end else if (timer != '0) begin
            timer_nxt = timer - TW'(1);
        end else begin
            timer_nxt = timer;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            row_reg     <= '0;
            plane       <= '0;
            len_reg     <= '0;
            timer       <= '0;
            wait_first  <= 1'b0;
            phy_blank   <= 1'b1;
            phy_le      <= 1'b0;
            phy_addr    <= '0;
            shift_go    <= 1'b0;
            shift_plane <= '0;
            bcm_rdy     <= 1'b1;
`ifdef HUB75_BCM_GUARD_EN
            guard_cnt   <= 1'b0;
`endif
        end else begin
            timer     <= timer_nxt;
            phy_blank <= (timer_nxt == '0);
            phy_le    <= 1'b0;
            shift_go  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bcm_go) begin
                        row_reg     <= bcm_row;
                        plane       <= '0;
                        if (bcm_row_first) begin
                            len_reg <= ctrl_len;
                        end
                        shift_go    <= 1'b1;
                        shift_plane <= '0;
                        bcm_rdy     <= 1'b0;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    wait_first <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    wait_first <= 1'b0;
                    // Previous plane must finish its on-time before the new data is latched.
                    if (!wait_first && shift_rdy && (timer == '0)) begin
                        phy_le   <= 1'b1;
                        phy_addr <= row_reg;
                        state    <= LATCH;
                    end
                end
                LATCH: begin
`ifdef HUB75_BCM_GUARD_EN
                    guard_cnt <= 1'b0;
                    state     <= GUARD;
`else
                    state     <= SHOW;
`endif
                end
`ifdef HUB75_BCM_GUARD_EN
                GUARD: begin
                    if (guard_cnt) begin
                        state <= SHOW;
                    end else begin
                        guard_cnt <= 1'b1;
                    end
                end
`endif
                SHOW: begin
                    if (plane == LAST_PLANE) begin
                        bcm_rdy <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        plane       <= plane + PW'(1);
                        shift_plane <= plane + PW'(1);
                        shift_go    <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_bcm.sv
// tb/tb_hub75_bcm.sv - scoreboard bench for hub75_bcm (4 planes, 8-bit length, 10-cycle shifter).
module tb_hub75_bcm;
    localparam int N_ROWS = 32;
    localparam int N_PLANES = 4;
    localparam int LEN_W = 8;
    localparam int LR = 5;
    localparam int PW = 2;
`ifdef HUB75_BCM_GUARD_EN
    localparam int EXP_GAP = 2;
`else
    localparam int EXP_GAP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LR-1:0] bcm_row = '0;
    logic          bcm_row_first = 1'b0;
    logic          bcm_go = 1'b0;
    logic          bcm_rdy;
    logic [PW-1:0] shift_plane;
    logic          shift_go;
    logic          shift_rdy;
    logic [LEN_W-1:0] ctrl_len = '0;
    logic [LR-1:0] phy_addr;
    logic          phy_le;
    logic          phy_blank;

    hub75_bcm #(.N_ROWS(N_ROWS), .N_PLANES(N_PLANES), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .bcm_row(bcm_row), .bcm_row_first(bcm_row_first),
        .bcm_go(bcm_go), .bcm_rdy(bcm_rdy), .shift_plane(shift_plane), .shift_go(shift_go),
        .shift_rdy(shift_rdy), .ctrl_len(ctrl_len), .phy_addr(phy_addr), .phy_le(phy_le),
        .phy_blank(phy_blank)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int exp_run[$], obs_run[$], exp_addr[$], obs_addr[$];
    int exp_gap[$], obs_gap[$], exp_plane[$], obs_plane[$];
    int run_len = 0;
    int gap = 0;
    bit gap_act = 0;
    int addr_viol = 0;
    int le_viol = 0;
    int len_model = 0;
    logic [LR-1:0] prev_addr = '0;
    int sh_cnt;

    always @(posedge clk) begin
        if (rst) begin
            sh_cnt <= 0;
            shift_rdy <= 1'b1;
        end else if (shift_go) begin
            sh_cnt <= 10;
            shift_rdy <= 1'b0;
        end else if (sh_cnt > 0) begin
            sh_cnt <= sh_cnt - 1;
            if (sh_cnt == 1) shift_rdy <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
            gap_act = 0;
            prev_addr = phy_addr;
        end else begin
            if (!phy_blank) run_len++;
            else if (run_len != 0) begin
                obs_run.push_back(run_len);
                run_len = 0;
            end
            if (gap_act) begin
                if (phy_blank) gap++;
                else begin
                    obs_gap.push_back(gap);
                    gap_act = 0;
                end
            end
            if (phy_le) begin
                obs_addr.push_back(int'(phy_addr));
                gap_act = 1;
                gap = 0;
                if (!phy_blank) le_viol++;
            end
            if (shift_go) obs_plane.push_back(int'(shift_plane));
            if (phy_addr != prev_addr && !phy_blank) addr_viol++;
            prev_addr = phy_addr;
        end
    end

    task automatic clear_queues();
        exp_run.delete(); obs_run.delete(); exp_addr.delete(); obs_addr.delete();
        exp_gap.delete(); obs_gap.delete(); exp_plane.delete(); obs_plane.delete();
    endtask

    task automatic paint(input int row, input bit first, input int len);
        int n = 0;
        @(negedge clk);
        while (!bcm_rdy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bcm_rdy !== 1'b1) begin
            failures++;
            $display("FAIL paint_rdy row=%0d got bcm_rdy=%b want 1", row, bcm_rdy);
        end
        ctrl_len = LEN_W'(len);
        bcm_row = LR'(row);
        bcm_row_first = first;
        bcm_go = 1'b1;
        if (first) len_model = len;
        for (int p = 0; p < N_PLANES; p++) begin
            exp_run.push_back((len_model + 1) << p);
            exp_addr.push_back(row);
            exp_gap.push_back(EXP_GAP);
            exp_plane.push_back(p);
        end
        @(negedge clk);
        bcm_go = 1'b0;
    endtask

    task automatic scoreboard(input string tag);
        int n = 0;
        while (!(obs_run.size() >= exp_run.size() && obs_addr.size() >= exp_addr.size() &&
                 obs_gap.size() >= exp_gap.size() && obs_plane.size() >= exp_plane.size()) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (obs_run.size() != exp_run.size()) begin
            failures++;
            $display("FAIL %s run_count got %0d want %0d", tag, obs_run.size(), exp_run.size());
        end
        checks++;
        if (obs_plane.size() != exp_plane.size()) begin
            failures++;
            $display("FAIL %s shift_go_count got %0d want %0d", tag, obs_plane.size(), exp_plane.size());
        end
        while (exp_run.size() > 0 && obs_run.size() > 0) begin
            int e = exp_run.pop_front();
            int o = obs_run.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s on_time got %0d want %0d", tag, o, e); end
        end
        while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
            int e = exp_addr.pop_front();
            int o = obs_addr.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s latch_addr got %0d want %0d", tag, o, e); end
        end
        while (exp_gap.size() > 0 && obs_gap.size() > 0) begin
            int e = exp_gap.pop_front();
            int o = obs_gap.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s guard_gap got %0d want %0d", tag, o, e); end
        end
        while (exp_plane.size() > 0 && obs_plane.size() > 0) begin
            int e = exp_plane.pop_front();
            int o = obs_plane.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s shift_plane got %0d want %0d", tag, o, e); end
        end
        clear_queues();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bcm_rdy, phy_blank, phy_le, shift_go} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_flags got rdy/blank/le/go=%b want 1100", {bcm_rdy, phy_blank, phy_le, shift_go});
        end
        checks++;
        if (phy_addr !== '0 || shift_plane !== '0) begin
            failures++;
            $display("FAIL reset_addr got addr=%0d plane=%0d want 0 0", phy_addr, shift_plane);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        paint(5, 1'b1, 3);
        scoreboard("single");
    endtask

    task automatic test_back_to_back();
        addr_viol = 0;
        le_viol = 0;
        paint(5, 1'b1, 3);
        paint(6, 1'b0, 3);
        scoreboard("back_to_back");
        checks++;
        if (addr_viol !== 0) begin
            failures++;
            $display("FAIL b2b_addr_unblanked got %0d want 0", addr_viol);
        end
        checks++;
        if (le_viol !== 0) begin
            failures++;
            $display("FAIL b2b_latch_unblanked got %0d want 0", le_viol);
        end
    endtask

    task automatic test_len_change();
        paint(7, 1'b0, 0);
        scoreboard("len_mid_frame");
        paint(8, 1'b1, 0);
        scoreboard("len_new_frame");
    endtask

    task automatic test_go_ignored();
        paint(9, 1'b1, 3);
        bcm_go = 1'b1;
        bcm_row = LR'(20);
        bcm_row_first = 1'b1;
        ctrl_len = '0;
        repeat (6) @(negedge clk);
        bcm_go = 1'b0;
        ctrl_len = LEN_W'(3);
        scoreboard("go_ignored");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        paint(10, 1'b1, 3);
        while ((obs_run.size() < 2 || phy_blank) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 5000) begin
            failures++;
            $display("FAIL reset_mid_plane2 got timeout want plane-2 on-time");
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (phy_blank !== 1'b1 || bcm_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got blank=%b rdy=%b want 1 1", phy_blank, bcm_rdy);
        end
        checks++;
        if (phy_addr !== '0 || shift_go !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_outs got addr=%0d go=%b want 0 0", phy_addr, shift_go);
        end
        rst = 1'b0;
        clear_queues();
        len_model = 0;
        paint(11, 1'b1, 2);
        scoreboard("after_reset");
    endtask

    task automatic test_guard_gap();
        paint(3, 1'b1, 1);
        scoreboard("guard_gap");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_len_change();
        test_go_ignored();
        test_reset_mid();
        test_guard_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hub75_bcm.md
HUB75_BCM -- requirements
Module: hub75_bcm

Interface
REQ-001 Parameters SHALL be: N_ROWS, default 32, number of scanned rows; N_PLANES, default 8, number of BCM bit-planes; LEN_W, default 8, width of the base on-time; LOG_N_ROWS, default $clog2(N_ROWS), auto-set.
REQ-002 Ports SHALL be:
- clk, in, 1, single clock.
- rst, in, 1, reset; synchronous, active-high.
- bcm_row, in, LOG_N_ROWS, row to display.
- bcm_row_first, in, 1, first row of a frame.
- bcm_go, in, 1, paint request.
- bcm_rdy, out, 1, ready for a paint request.
- shift_plane, out, $clog2(N_PLANES), plane to shift out.
- shift_go, out, 1, start the shifter.
- shift_rdy, in, 1, shifter idle and data shifted.
- ctrl_len, in, LEN_W, base on-time minus one.
- phy_addr, out, LOG_N_ROWS, panel row address.
- phy_le, out, 1, panel latch.
- phy_blank, out, 1, panel output-enable, active-high blank.

Function
REQ-003 The FSM SHALL have the states IDLE, SHIFT, WAIT, LATCH and SHOW (plus GUARD, see REQ-016).
REQ-004 bcm_rdy SHALL be 1 only in IDLE; bcm_go SHALL be ignored in every other state.
REQ-005 On IDLE with bcm_go=1, the block SHALL capture bcm_row into row_reg, set plane=0, capture ctrl_len into len_reg only if bcm_row_first=1, and go to SHIFT.
REQ-006 SHIFT SHALL assert shift_go for exactly 1 cycle with shift_plane=plane, then go to WAIT.
REQ-007 WAIT SHALL ignore shift_rdy in its first cycle.
REQ-008 From its second cycle on, WAIT SHALL go to LATCH when shift_rdy=1 and timer==0 are both true in the same cycle; otherwise it SHALL stay in WAIT.
REQ-009 LATCH SHALL assert phy_le for exactly 1 cycle and load phy_addr<=row_reg, visible from the next cycle.
- The address change SHALL always occur while phy_blank=1.
REQ-010 SHOW SHALL load timer <= (len_reg+1) << plane.
- If plane==N_PLANES-1, SHOW SHALL go to IDLE; otherwise it SHALL increment plane and go to SHIFT.
- Plane p+1 therefore shifts while plane p is displayed.
REQ-011 timer SHALL be LEN_W+N_PLANES bits wide, decrement by 1 each cycle while nonzero, and never wrap below 0.
REQ-012 phy_blank SHALL equal (timer==0), registered; the panel SHALL be unblanked for exactly (len_reg+1)<<plane cycles per plane.
REQ-013 Returning to IDLE SHALL NOT wait for the last plane's on-time; the next row's LATCH is held off by REQ-008.
REQ-014 A ctrl_len change SHALL take effect only at the next paint request with bcm_row_first=1, never in the middle of a frame.

Reset
REQ-015 With rst=1 at a clock edge, the block SHALL enter IDLE and set the following, regardless of the state it was in (mid-row included):
- timer=0, plane=0, len_reg=0, row_reg=0;
- phy_blank=1, phy_le=0, phy_addr=0;
- shift_go=0, shift_plane=0, bcm_rdy=1 on the next cycle.

Configuration
REQ-016 With HUB75_BCM_GUARD_EN defined, LATCH SHALL go to GUARD, which holds for exactly 2 cycles with phy_blank=1 and then goes to SHOW.
- Without the macro, LATCH SHALL go directly to SHOW and the GUARD state SHALL NOT exist.

Verification
REQ-017 The bench SHALL cover the following directed scenarios (N_PLANES=4, LEN_W=8, shifter modelled with shift_rdy low for 10 cycles after shift_go):
- Reset, then ctrl_len=3, bcm_go with bcm_row=5 and bcm_row_first=1 -> phy_addr=5 after the first phy_le; phy_blank low for runs of 4, 8, 16 and 32 cycles, with a latch between each run.
- Two back-to-back rows, 5 then 6 -> phy_addr changes to 6 only while phy_blank=1; the LATCH of row 6 plane 0 occurs only after the 32-cycle run ends.
- ctrl_len changed to 0 mid-frame with bcm_row_first=0 -> on-times remain 4/8/16/32; the next request with bcm_row_first=1 gives 1/2/4/8.
- bcm_go pulsed during SHIFT or WAIT -> ignored: no capture and no extra shift_go.
- rst asserted in the middle of a plane-2 on-time -> phy_blank=1 and bcm_rdy=1 the next cycle; a fresh bcm_go then restarts at plane 0.
- With HUB75_BCM_GUARD_EN defined -> exactly 2 blanked cycles between the phy_le pulse and the start of the on-time; without the macro -> 0.
